// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - stage indices, result-stage codes and select-width helper for the forwarding unit
package fwd_pkg;

   localparam int STG_ID  = 0;
   localparam int STG_EX  = 1;
   localparam int STG_MEM = 2;
   localparam int STG_WB  = 3;

   localparam int RES_PC  = 1;
   localparam int RES_ALU = 2;
   localparam int RES_DM  = 3;

   function automatic int sel_w(input int num_stg);
      return $clog2(num_stg + 1);
   endfunction

endpackage

// File: rtl/fwd_pick.sv
// rtl/fwd_pick.sv - youngest-match forward select and late-result flag over the shadow pipeline
module fwd_pick #(
   parameter int NUM_STG = 3,
   parameter int RA_W    = 5,
   parameter int SEL_W   = 2,
   parameter int MIN_STG = 1
) (
   input  logic [NUM_STG-1:0]            vld_i,
   input  logic [NUM_STG-1:0][RA_W-1:0]  wa_i,
   input  logic [NUM_STG-1:0][SEL_W-1:0] res_stg_i,
   input  logic [RA_W-1:0]               ra_i,
   input  logic [SEL_W-1:0]              use_i,
   output logic [SEL_W-1:0]              sel_o,
   output logic                          late_o
);

   logic unused_lo;
   assign unused_lo = ^{vld_i, wa_i, res_stg_i};

   // Walk oldest to youngest so the youngest matching writer overwrites older ones.
   always_comb begin
      sel_o  = '0;
      late_o = 1'b0;
      for (int k = NUM_STG; k >= MIN_STG; k--) begin
         if (vld_i[k-1] && (wa_i[k-1] == ra_i) && (ra_i != '0)) begin
            sel_o  = (int'(res_stg_i[k-1]) <= k) ? SEL_W'(k) : '0;
            late_o = int'(res_stg_i[k-1]) > (k + int'(use_i));
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard_pipe.sv
// rtl/fwd_scoreboard_pipe.sv - shadow writer pipeline driving forward selects, hazard stall and mult/div busy
module fwd_scoreboard_pipe
   import fwd_pkg::*;
#(
   parameter int NUM_STG = 3,
   parameter int RA_W    = 5,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10,
   parameter int SEL_W   = sel_w(NUM_STG)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             id_valid_i,
   input  logic [RA_W-1:0]  id_rs_i,
   input  logic [RA_W-1:0]  id_rt_i,
   input  logic [SEL_W-1:0] id_rs_use_i,
   input  logic [SEL_W-1:0] id_rt_use_i,
   input  logic [RA_W-1:0]  id_wa_i,
   input  logic [SEL_W-1:0] id_res_stg_i,
   input  logic             id_md_start_i,
   input  logic             id_md_div_i,
   input  logic             id_md_use_i,
   output logic             stall_o,
   output logic [SEL_W-1:0] id_rs_sel_o,
   output logic [SEL_W-1:0] id_rt_sel_o,
   output logic [SEL_W-1:0] ex_rs_sel_o,
   output logic [SEL_W-1:0] ex_rt_sel_o,
   output logic [SEL_W-1:0] mem_rt_sel_o,
   output logic             md_busy_o
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef struct packed {
      logic             vld;
      logic [RA_W-1:0]  wa;
      logic [SEL_W-1:0] res_stg;
      logic [RA_W-1:0]  rs;
      logic [RA_W-1:0]  rt;
   } entry_t;

   // Array index k-1 holds entry k (entry 1 = EX input register).
   entry_t ent_q [NUM_STG];
   entry_t ent_d [NUM_STG];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [NUM_STG-1:0]            vld_v;
   logic [NUM_STG-1:0][RA_W-1:0]  wa_v;
   logic [NUM_STG-1:0][SEL_W-1:0] res_v;
   logic haz_rs, haz_rt, issue;
   logic ex_rs_late, ex_rt_late, mem_rt_late, unused_late;

   always_comb begin
      for (int k = 0; k < NUM_STG; k++) begin
         vld_v[k] = ent_q[k].vld;
         wa_v[k]  = ent_q[k].wa;
         res_v[k] = ent_q[k].res_stg;
      end
   end

   fwd_pick #(.NUM_STG(NUM_STG), .RA_W(RA_W), .SEL_W(SEL_W), .MIN_STG(STG_EX)) u_pick_id_rs (
      .vld_i(vld_v), .wa_i(wa_v), .res_stg_i(res_v), .ra_i(id_rs_i), .use_i(id_rs_use_i),
      .sel_o(id_rs_sel_o), .late_o(haz_rs));

   fwd_pick #(.NUM_STG(NUM_STG), .RA_W(RA_W), .SEL_W(SEL_W), .MIN_STG(STG_EX)) u_pick_id_rt (
      .vld_i(vld_v), .wa_i(wa_v), .res_stg_i(res_v), .ra_i(id_rt_i), .use_i(id_rt_use_i),
      .sel_o(id_rt_sel_o), .late_o(haz_rt));

   fwd_pick #(.NUM_STG(NUM_STG), .RA_W(RA_W), .SEL_W(SEL_W), .MIN_STG(STG_MEM)) u_pick_ex_rs (
      .vld_i(vld_v), .wa_i(wa_v), .res_stg_i(res_v), .ra_i(ent_q[0].rs), .use_i('0),
      .sel_o(ex_rs_sel_o), .late_o(ex_rs_late));

   fwd_pick #(.NUM_STG(NUM_STG), .RA_W(RA_W), .SEL_W(SEL_W), .MIN_STG(STG_MEM)) u_pick_ex_rt (
      .vld_i(vld_v), .wa_i(wa_v), .res_stg_i(res_v), .ra_i(ent_q[0].rt), .use_i('0),
      .sel_o(ex_rt_sel_o), .late_o(ex_rt_late));

   fwd_pick #(.NUM_STG(NUM_STG), .RA_W(RA_W), .SEL_W(SEL_W), .MIN_STG(STG_WB)) u_pick_mem_rt (
      .vld_i(vld_v), .wa_i(wa_v), .res_stg_i(res_v), .ra_i(ent_q[1].rt), .use_i('0),
      .sel_o(mem_rt_sel_o), .late_o(mem_rt_late));

   // Consumers past ID never see a late result: the ID stall already held them back.
   assign unused_late = ex_rs_late ^ ex_rt_late ^ mem_rt_late;
   assign md_busy_o   = (cnt_q != '0);

   always_comb begin
      stall_o = id_valid_i & (haz_rs | haz_rt | (id_md_use_i & md_busy_o));
      issue   = id_valid_i & ~stall_o & ~flush_i;
      ent_d[0] = '0;
      if (issue) begin
         ent_d[0].vld     = 1'b1;
         ent_d[0].wa      = id_wa_i;
         ent_d[0].res_stg = id_res_stg_i;
         ent_d[0].rs      = id_rs_i;
         ent_d[0].rt      = id_rt_i;
      end
      for (int k = 1; k < NUM_STG; k++) begin
         ent_d[k] = flush_i ? '0 : ent_q[k-1];
      end
      // Flush leaves the counter alone: an issued mult/div still completes.
      cnt_d = cnt_q;
      if (issue && id_md_start_i) begin
         cnt_d = id_md_div_i ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int k = 0; k < NUM_STG; k++) begin
            ent_q[k] <= '0;
         end
         cnt_q <= '0;
      end else begin
         ent_q <= ent_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard_pipe.sv
// tb/tb_fwd_scoreboard_pipe.sv - directed and random checks of fwd_scoreboard_pipe against an issue-history model
module tb_fwd_scoreboard_pipe;
   import fwd_pkg::*;

   localparam int N = 3, RA_W = 5, MUL = 5, DIV = 10, SW = 2, D = 4096;

   logic clk = 1'b0;
   logic reset_i, flush_i, id_valid_i, id_md_start_i, id_md_div_i, id_md_use_i;
   logic [RA_W-1:0] id_rs_i, id_rt_i, id_wa_i;
   logic [SW-1:0] id_rs_use_i, id_rt_use_i, id_res_stg_i;
   logic stall_o, md_busy_o;
   logic [SW-1:0] id_rs_sel_o, id_rt_sel_o, ex_rs_sel_o, ex_rt_sel_o, mem_rt_sel_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fwd_scoreboard_pipe #(.NUM_STG(N), .RA_W(RA_W), .MUL_LAT(MUL), .DIV_LAT(DIV)) dut (
      .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rs_use_i(id_rs_use_i), .id_rt_use_i(id_rt_use_i),
      .id_wa_i(id_wa_i), .id_res_stg_i(id_res_stg_i), .id_md_start_i(id_md_start_i),
      .id_md_div_i(id_md_div_i), .id_md_use_i(id_md_use_i), .stall_o(stall_o),
      .id_rs_sel_o(id_rs_sel_o), .id_rt_sel_o(id_rt_sel_o), .ex_rs_sel_o(ex_rs_sel_o),
      .ex_rt_sel_o(ex_rt_sel_o), .mem_rt_sel_o(mem_rt_sel_o), .md_busy_o(md_busy_o));

   // Model: an instruction issued at edge e sits in stage (edge_n - e + 1); anything
   // issued at or before the last flush/reset edge is dead.
   int edge_n = 0, kill_edge = 0, md_end = 0;
   bit iss_v [D];
   int iss_wa [D], iss_res [D], iss_rs [D], iss_rt [D];

   function automatic int m_idx(input int k);
      return (edge_n - k + 1) % D;
   endfunction

   function automatic bit m_vld(input int k);
      int e;
      e = edge_n - k + 1;
      return (e > kill_edge) && (e >= 1) && iss_v[e % D];
   endfunction

   function automatic int m_young(input int r, input int kmin);
      for (int k = kmin; k <= N; k++)
         if (m_vld(k) && r != 0 && iss_wa[m_idx(k)] == r) return k;
      return 0;
   endfunction

   function automatic int m_sel(input int r, input int kmin);
      int k;
      k = m_young(r, kmin);
      if (k != 0 && iss_res[m_idx(k)] <= k) return k;
      return 0;
   endfunction

   function automatic bit m_late(input int r, input int use_stg);
      int k;
      k = m_young(r, STG_EX);
      return (k != 0) && (iss_res[m_idx(k)] > k + use_stg);
   endfunction

   function automatic bit m_stall();
      return id_valid_i && (m_late(int'(id_rs_i), int'(id_rs_use_i)) ||
             m_late(int'(id_rt_i), int'(id_rt_use_i)) || (id_md_use_i && edge_n < md_end));
   endfunction

   always @(posedge clk) begin
      edge_n <= edge_n + 1;
      iss_v[(edge_n + 1) % D]   <= !reset_i && !flush_i && id_valid_i && !m_stall();
      iss_wa[(edge_n + 1) % D]  <= int'(id_wa_i);
      iss_res[(edge_n + 1) % D] <= int'(id_res_stg_i);
      iss_rs[(edge_n + 1) % D]  <= int'(id_rs_i);
      iss_rt[(edge_n + 1) % D]  <= int'(id_rt_i);
      if (reset_i || flush_i) kill_edge <= edge_n + 1;
      if (reset_i) md_end <= 0;
      else if (!flush_i && id_valid_i && !m_stall() && id_md_start_i)
         md_end <= edge_n + 1 + (id_md_div_i ? DIV : MUL);
   end

   task automatic drive(input bit v, input int rs, input int rt, input int rsu, input int rtu,
                        input int wa, input int res, input bit mds, input bit mdd, input bit mdu,
                        input bit fl, input bit rst);
      @(negedge clk);
      id_valid_i = v; id_rs_i = RA_W'(rs); id_rt_i = RA_W'(rt);
      id_rs_use_i = SW'(rsu); id_rt_use_i = SW'(rtu); id_wa_i = RA_W'(wa);
      id_res_stg_i = SW'(res); id_md_start_i = mds; id_md_div_i = mdd; id_md_use_i = mdu;
      flush_i = fl; reset_i = rst;
      #1;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 1, 2, STG_ID, STG_ID, 0, RES_ALU, 0, 0, 1, 0, 0);
      checks++;
      if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
      checks++;
      if ({id_rs_sel_o, id_rt_sel_o, ex_rs_sel_o, ex_rt_sel_o, mem_rt_sel_o} !== '0) begin
         failures++; $display("FAIL reset_sels: got %h want 0", {id_rs_sel_o, id_rt_sel_o, ex_rs_sel_o, ex_rt_sel_o, mem_rt_sel_o});
      end
      checks++;
      if (md_busy_o !== 1'b0) begin failures++; $display("FAIL reset_md_busy: got %0b want 0", md_busy_o); end
   endtask

   task automatic test_load_use();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, STG_EX, STG_EX, 8, RES_DM, 0, 0, 0, 0, 0);
      drive(1, 8, 8, STG_EX, STG_EX, 9, RES_ALU, 0, 0, 0, 0, 0);
      checks++;
      if (stall_o !== 1'b1) begin failures++; $display("FAIL load_use_stall: got %0b want 1", stall_o); end
      drive(1, 8, 8, STG_EX, STG_EX, 9, RES_ALU, 0, 0, 0, 0, 0);
      checks++;
      if (stall_o !== 1'b0) begin failures++; $display("FAIL load_use_release: got %0b want 0", stall_o); end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (ex_rs_sel_o !== 2'd3 || ex_rt_sel_o !== 2'd3) begin
         failures++; $display("FAIL load_use_ex_sel: got rs=%0d rt=%0d want 3/3", ex_rs_sel_o, ex_rt_sel_o);
      end
   endtask

   task automatic test_branch();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, STG_EX, STG_EX, 8, RES_ALU, 0, 0, 0, 0, 0);
      drive(1, 8, 0, STG_ID, STG_ID, 0, RES_ALU, 0, 0, 0, 0, 0);
      checks++;
      if (stall_o !== 1'b1) begin failures++; $display("FAIL branch_stall: got %0b want 1", stall_o); end
      drive(1, 8, 0, STG_ID, STG_ID, 0, RES_ALU, 0, 0, 0, 0, 0);
      checks++;
      if (stall_o !== 1'b0 || id_rs_sel_o !== 2'd2) begin
         failures++; $display("FAIL branch_fwd: got stall=%0b sel=%0d want 0/2", stall_o, id_rs_sel_o);
      end
   endtask

   task automatic test_jal();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, STG_EX, STG_EX, 31, RES_PC, 0, 0, 0, 0, 0);
      drive(1, 31, 0, STG_ID, STG_EX, 0, RES_ALU, 0, 0, 0, 0, 0);
      checks++;
      if (stall_o !== 1'b0 || id_rs_sel_o !== 2'd1) begin
         failures++; $display("FAIL jal_jr: got stall=%0b sel=%0d want 0/1", stall_o, id_rs_sel_o);
      end
   endtask

   task automatic test_youngest();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, STG_EX, STG_EX, 8, RES_ALU, 0, 0, 0, 0, 0);
      drive(1, 0, 0, STG_EX, STG_EX, 8, RES_ALU, 0, 0, 0, 0, 0);
      drive(1, 0, 8, STG_EX, STG_MEM, 0, RES_ALU, 0, 0, 0, 0, 0);
      checks++;
      if (stall_o !== 1'b0) begin failures++; $display("FAIL store_stall: got %0b want 0", stall_o); end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (ex_rt_sel_o !== 2'd2 || mem_rt_sel_o !== 2'd0) begin
         failures++; $display("FAIL youngest_sel: got ex_rt=%0d mem_rt=%0d want 2/0", ex_rt_sel_o, mem_rt_sel_o);
      end
   endtask

   task automatic test_md();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 1, 2, STG_EX, STG_EX, 0, RES_ALU, 1, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, STG_EX, STG_EX, 8, RES_ALU, 0, 0, 1, 0, 0);
         checks++;
         if (stall_o !== 1'b1 || md_busy_o !== 1'b1) begin
            failures++; $display("FAIL md_stall_%0d: got stall=%0b busy=%0b want 1/1", i, stall_o, md_busy_o);
         end
      end
      drive(1, 0, 0, STG_EX, STG_EX, 8, RES_ALU, 0, 0, 1, 0, 0);
      checks++;
      if (stall_o !== 1'b0 || md_busy_o !== 1'b0) begin
         failures++; $display("FAIL md_release: got stall=%0b busy=%0b want 0/0", stall_o, md_busy_o);
      end
   endtask

   task automatic test_flush();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, STG_EX, STG_EX, 8, RES_DM, 0, 0, 0, 0, 0);
      drive(1, 8, 8, STG_EX, STG_EX, 9, RES_ALU, 0, 0, 0, 1, 0);
      drive(1, 8, 8, STG_EX, STG_EX, 9, RES_ALU, 0, 0, 0, 0, 0);
      checks++;
      if (stall_o !== 1'b0 || {id_rs_sel_o, id_rt_sel_o, ex_rs_sel_o, ex_rt_sel_o, mem_rt_sel_o} !== '0) begin
         failures++; $display("FAIL flush_clear: got stall=%0b sels=%h want 0/0", stall_o, {id_rs_sel_o, id_rt_sel_o, ex_rs_sel_o, ex_rt_sel_o, mem_rt_sel_o});
      end
      drive(1, 0, 0, STG_EX, STG_EX, 8, RES_DM, 0, 0, 0, 0, 0);
      drive(1, 8, 8, STG_EX, STG_EX, 9, RES_ALU, 0, 0, 0, 0, 1);
      drive(1, 8, 8, STG_EX, STG_EX, 9, RES_ALU, 0, 0, 0, 0, 0);
      checks++;
      if (stall_o !== 1'b0 || {id_rs_sel_o, id_rt_sel_o, ex_rs_sel_o, ex_rt_sel_o, mem_rt_sel_o} !== '0) begin
         failures++; $display("FAIL reset_mid_stall: got stall=%0b sels=%h want 0/0", stall_o, {id_rs_sel_o, id_rt_sel_o, ex_rs_sel_o, ex_rt_sel_o, mem_rt_sel_o});
      end
      drive(1, 1, 2, STG_EX, STG_EX, 0, RES_ALU, 1, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (md_busy_o !== 1'b1) begin failures++; $display("FAIL flush_keeps_md: got %0b want 1", md_busy_o); end
   endtask

   task automatic test_random(input int cycles);
      bit v, mds, mdd, mdu, fl, rst, hold;
      int rs, rt, rsu, rtu, wa, res;
      int act [7];
      int exp [7];
      string nm [7];
      nm = '{"stall", "id_rs_sel", "id_rt_sel", "ex_rs_sel", "ex_rt_sel", "mem_rt_sel", "md_busy"};
      hold = 0;
      v = 0; mds = 0; mdd = 0; mdu = 0; rs = 0; rt = 0; rsu = 0; rtu = 0; wa = 0; res = RES_ALU;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < cycles; i++) begin
         if (!hold) begin
            v   = ($urandom_range(0, 4) != 0);
            rs  = $urandom_range(0, 3);
            rt  = $urandom_range(0, 3);
            wa  = $urandom_range(0, 3);
            rsu = $urandom_range(STG_ID, STG_EX);
            rtu = $urandom_range(STG_ID, STG_MEM);
            res = $urandom_range(RES_PC, RES_DM);
            mds = ($urandom_range(0, 15) == 0);
            mdd = $urandom_range(0, 1);
            mdu = mds | ($urandom_range(0, 7) == 0);
         end
         fl  = ($urandom_range(0, 24) == 0);
         rst = ($urandom_range(0, 99) == 0);
         drive(v, rs, rt, rsu, rtu, wa, res, mds, mdd, mdu, fl, rst);
         act = '{int'(stall_o), int'(id_rs_sel_o), int'(id_rt_sel_o), int'(ex_rs_sel_o),
                 int'(ex_rt_sel_o), int'(mem_rt_sel_o), int'(md_busy_o)};
         exp[0] = int'(m_stall());
         exp[1] = m_sel(int'(id_rs_i), STG_EX);
         exp[2] = m_sel(int'(id_rt_i), STG_EX);
         exp[3] = m_sel(m_vld(1) ? iss_rs[m_idx(1)] : 0, STG_MEM);
         exp[4] = m_sel(m_vld(1) ? iss_rt[m_idx(1)] : 0, STG_MEM);
         exp[5] = m_sel(m_vld(2) ? iss_rt[m_idx(2)] : 0, STG_WB);
         exp[6] = int'(edge_n < md_end);
         for (int j = 0; j < 7; j++) begin
            checks++;
            if ($isunknown(act[j]) || act[j] != exp[j]) begin
               failures++;
               $display("FAIL rand_%s cycle %0d: got %0d want %0d", nm[j], i, act[j], exp[j]);
            end
         end
         hold = (exp[0] != 0) && !fl && !rst;
      end
   endtask

   initial begin
      reset_i = 1'b1; flush_i = 1'b0; id_valid_i = 1'b0;
      id_rs_i = '0; id_rt_i = '0; id_wa_i = '0;
      id_rs_use_i = '0; id_rt_use_i = '0; id_res_stg_i = '0;
      id_md_start_i = 1'b0; id_md_div_i = 1'b0; id_md_use_i = 1'b0;
      test_reset();
      test_load_use();
      test_branch();
      test_jal();
      test_youngest();
      test_md();
      test_flush();
      test_random(1500);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
